aoi_sweep_tester: RTL
=====================

# aoi_sweep_tester

Self-checking stimulus engine for the 4-input AND-OR-INVERT cell (y = ~((a&b)|(c&d))). It drives a, b, c and d into a device under test and captures y, which is the opposite direction of the gate's own interface. On each start it sweeps all 16 input combinations and builds the observed truth table. It compares that table against an expected signature and reports pass/fail, the error count and the first failing vector. It sits beside the AOI cell on the lab board or in a bench.

## Interface
- SETTLE, default 2: extra hold cycles per vector before y is sampled, range 0–15.
- EXPECTED, default 16'h0777: expected truth table; bit i holds y for {a,b,c,d} = i.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request, sampled in IDLE only.
- y  input  1  output of the gate under test.
- a, b, c, d  output  1 each  stimulus to the gate under test; {a,b,c,d} = vector index.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when results become valid.
- pass  output  1  high when the observed table equals EXPECTED.
- table  output  16  observed truth table.
- err_cnt  output  5  number of mismatching vectors, 0–16.
- fail_idx  output  4  lowest mismatching index; 0 when pass.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - a..d = 0, busy = 0.
  - start = 1 → RUN. Same edge sets idx = 0 and cnt = 0, and clears table, err_cnt, fail_idx and pass.
- RUN:
  - busy = 1; {a,b,c,d} = idx.
  - cnt < HOLD: cnt increments.
  - cnt == HOLD:
    - table[idx] ← y_s; cnt ← 0.
    - If y_s ≠ EXPECTED[idx]: err_cnt increments; if err_cnt was 0, fail_idx ← idx.
    - idx == 15 → FIN; otherwise idx increments.
- FIN (one cycle):
  - done = 1, busy = 1; pass = (err_cnt == 0).
  - Next cycle → IDLE.
- table, err_cnt, fail_idx and pass hold their values until the next accepted start.
- start while busy is ignored; no queuing.
- idx is 4 bits and is never incremented past 15.
- err_cnt is 5 bits and cannot overflow.
- HOLD = SETTLE without the synchronizer and SETTLE+2 with it.
- y_s = y without the synchronizer, or the synchronizer output with it.

## Timing
- Reset value of every output is 0: a, b, c, d, busy, done, pass, table, err_cnt, fail_idx.
- rst_n low mid-sweep: state, counters and outputs clear immediately, asynchronously. The sweep is abandoned and done does not pulse.
- Start sampled at edge 0 → busy = 1 and vector 0 driven from cycle 1.
- Each vector is held for HOLD+1 cycles.
- done is high in cycle 16·(HOLD+1)+1 and is low in every other cycle.
- Back-to-back sweeps: start held high across FIN is accepted at the first IDLE cycle. Minimum gap between sweeps is one IDLE cycle.
- Outputs a..d are registered and change only on a vector boundary.

## Configuration
- AOI_SWEEP_SYNC_EN defined:
  - y passes through a two-flop synchronizer before sampling.
  - HOLD = SETTLE+2.
  - Use this when y comes from an asynchronous or off-chip gate.
- Undefined:
  - y is sampled directly.
  - HOLD = SETTLE.
  - Sweep latency is shorter by 32 cycles.

## Test plan
- Ideal AOI model, SETTLE=2, start pulse at cycle 0:
  - done at cycle 49.
  - table = 16'h0777, pass = 1, err_cnt = 0, fail_idx = 0.
- Faulty model y = ~(a&b):
  - table = 16'h0FFF, pass = 0, err_cnt = 3, fail_idx = 3.
- y stuck at 0:
  - table = 16'h0000, err_cnt = 9, fail_idx = 0, pass = 0.
- start pulsed again mid-sweep (cycle 20):
  - Ignored; single done at cycle 49; results unchanged vs. the ideal run.
- rst_n low at cycle 30 for 2 cycles:
  - All outputs 0 immediately; no done.
  - New start after release gives a full correct sweep.
- AOI_SWEEP_SYNC_EN defined, ideal model, SETTLE=2:
  - done at cycle 81; table = 16'h0777, pass = 1.

Source files
------------

// File: rtl/aoi_sweep_tester.sv
// rtl/aoi_sweep_tester.sv - truth-table sweep tester for a 4-input AND-OR-INVERT cell
// Optional feature macro: AOI_SWEEP_SYNC_EN (two-flop synchronizer on y, HOLD = SETTLE+2).
// The observed table is exported on port truth_table.
module aoi_sweep_tester #(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'h0777
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_table,
  output logic [4:0]  err_cnt,
  output logic [3:0]  fail_idx
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

`ifdef AOI_SWEEP_SYNC_EN
  localparam logic [4:0] HOLD = 5'(SETTLE) + 5'd2;
`else
  localparam logic [4:0] HOLD = 5'(SETTLE);
`endif

  logic [1:0] state;
  logic [3:0] idx;
  logic [4:0] cnt;
  logic       y_s;

`ifdef AOI_SWEEP_SYNC_EN
  logic y_meta;
  logic y_sync;

  // Two-flop synchronizer for a y that may come from an asynchronous gate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_meta <= 1'b0;
      y_sync <= 1'b0;
    end else begin
      y_meta <= y;
      y_sync <= y_meta;
    end
  end

  assign y_s = y_sync;
`else
  assign y_s = y;
`endif

  // idx returns to 0 outside RUN, so the stimulus is all-zero while idle
  assign {a, b, c, d} = idx;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN);

  // Sweep sequencer: hold each vector HOLD+1 cycles, sample y on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= 4'd0;
      cnt         <= 5'd0;
      truth_table <= 16'h0000;
      err_cnt     <= 5'd0;
      fail_idx    <= 4'd0;
      pass        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_RUN;
            idx         <= 4'd0;
            cnt         <= 5'd0;
            truth_table <= 16'h0000;
            err_cnt     <= 5'd0;
            fail_idx    <= 4'd0;
            pass        <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt != HOLD) begin
            cnt <= cnt + 5'd1;
          end else begin
            cnt              <= 5'd0;
            truth_table[idx] <= y_s;
            if (y_s != EXPECTED[idx]) begin
              err_cnt <= err_cnt + 5'd1;
              if (err_cnt == 5'd0) begin
                fail_idx <= idx;
              end
            end
            if (idx == 4'd15) begin
              // pass must already be valid while done is high, so fold in the last vector here
              state <= ST_FIN;
              idx   <= 4'd0;
              pass  <= (err_cnt == 5'd0) && (y_s == EXPECTED[15]);
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
